// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the MMIO UART transmit bridge: FSM encoding,
// status register bit positions and the ASCII digit offset helper.
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // Byte actually queued for a CPU write; the offset turns 0..9 into '0'..'9'.
    function automatic logic [7:0] encode_tx_byte(input logic [7:0] raw, input logic ascii_en);
        return ascii_en ? (raw + ASCII_ZERO) : raw;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_bridge_if.sv
// CPU data-memory bus as seen by the UART transmit bridge; the CPU side is the
// master, the bridge is the slave.
interface mmio_uart_tx_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic                  bus_memwrite;
    logic                  bus_memread;
    logic [31:0]           bus_rdata;
    logic                  bus_rd_hit;
    logic                  bus_stall;

    modport master (
        output bus_addr, bus_wdata, bus_memwrite, bus_memread,
        input  bus_rdata, bus_rd_hit, bus_stall
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_memwrite, bus_memread,
        output bus_rdata, bus_rd_hit, bus_stall
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; DEPTH must be a
// power of two (>= 2) so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // Flush dominates: a coinciding push or pop is dropped.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx_bridge.sv
// Memory-mapped bridge from the CPU data bus into uart_tx: TX writes are queued,
// drained through the data/start/ready handshake, and stall the CPU when full.
// Build option: define MMIO_UART_ASCII_OFFSET_EN to add ASCII '0' to each byte.
module mmio_uart_tx_bridge
    import mmio_uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] TX_ADDR     = 32'h0000_2000,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 32'h0000_2004,
    parameter int                    FIFO_DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    mmio_uart_tx_bridge_if.slave      bus,
    output logic [7:0]                tx_data,
    output logic                      tx_start,
    input  logic                      tx_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             tx_hit;
    logic             status_wr_hit;
    logic             flush;
    logic             push;
    logic             pop;
    logic [7:0]       push_byte;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      status_word;
    logic             unused_wdata;

    state_e     state_q, state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;

    assign tx_hit        = bus.bus_memwrite && (bus.bus_addr == TX_ADDR);
    assign status_wr_hit = bus.bus_memwrite && (bus.bus_addr == STATUS_ADDR);
    assign flush         = status_wr_hit && bus.bus_wdata[0];
    assign push          = tx_hit && !fifo_full;
    assign bus.bus_stall = tx_hit && fifo_full;
    assign unused_wdata  = &{1'b0, bus.bus_wdata[31:8]};

`ifdef MMIO_UART_ASCII_OFFSET_EN
    assign push_byte = encode_tx_byte(bus.bus_wdata[7:0], 1'b1);
`else
    assign push_byte = encode_tx_byte(bus.bus_wdata[7:0], 1'b0);
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_byte),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A flush in the same cycle suppresses the pop so no stale byte is launched.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && tx_ready && !flush) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_rdata;
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (!tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (tx_ready) state_d = IDLE;
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    always_comb begin
        status_word                              = '0;
        status_word[ST_EMPTY]                    = fifo_empty;
        status_word[ST_FULL]                     = fifo_full;
        status_word[ST_BUSY]                     = (state_q != IDLE);
        status_word[ST_COUNT_LSB +: CNT_W]       = fifo_count;
    end

    assign bus.bus_rd_hit = bus.bus_memread && (bus.bus_addr == STATUS_ADDR);
    assign bus.bus_rdata  = bus.bus_rd_hit ? status_word : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx_bridge.sv
// Self-checking bench: a small uart_tx model acknowledges start pulses and
// compares each transmitted byte with a scoreboard filled on accepted writes.
module tb_mmio_uart_tx_bridge;

    localparam logic [31:0] TX_ADDR     = 32'h0000_2000;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_2004;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_start;

    mmio_uart_tx_bridge_if #(.ADDR_WIDTH(32)) bus_if ();

    mmio_uart_tx_bridge #(
        .ADDR_WIDTH  (32),
        .TX_ADDR     (TX_ADDR),
        .STATUS_ADDR (STATUS_ADDR),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus_if),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sbq [$];
    bit         hold = 1'b0;
    bit         ack_en = 1'b1;
    int         busy_len = 3;
    int         busy_cnt = 0;
    int         start_cnt = 0;
    logic       start_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] raw);
`ifdef MMIO_UART_ASCII_OFFSET_EN
        return raw + 8'h30;
`else
        return raw;
`endif
    endfunction

    // uart_tx model: acknowledges a start one cycle later, stays busy busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rstn) begin
                tx_ready   = 1'b1;
                busy_cnt   = 0;
                start_prev = 1'b0;
            end else begin
                if (tx_start && !start_prev) start_cnt++;
                start_prev = tx_start;
                if (hold) begin
                    tx_ready = 1'b0;
                end else if (tx_ready) begin
                    if (tx_start && ack_en) begin
                        $display("uart byte %h", tx_data);
                        if (sbq.size() == 0)
                            check("sb_extra_byte", {24'h0, tx_data}, 32'h100);
                        else
                            check("sb_order", {24'h0, tx_data}, {24'h0, sbq.pop_front()});
                        tx_ready = 1'b0;
                        busy_cnt = busy_len;
                    end
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output logic st0);
        int   n;
        logic acc;
        n = 0;
        @(negedge clk);
        bus_if.bus_addr     = a;
        bus_if.bus_wdata    = d;
        bus_if.bus_memwrite = 1'b1;
        #1;
        st0 = bus_if.bus_stall;
        while (bus_if.bus_stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus_if.bus_stall) check("wr_stall_timeout", 32'(bus_if.bus_stall), 32'h0);
        acc = !bus_if.bus_stall;
        @(posedge clk);
        if (a == TX_ADDR && acc) sbq.push_back(exp_byte(d[7:0]));
        #1;
        bus_if.bus_memwrite = 1'b0;
        $display("cpu write addr=%h data=%h stall_first=%0b", a, d, st0);
    endtask

    task automatic read_status(output logic [31:0] v, output logic hit);
        @(negedge clk);
        bus_if.bus_addr    = STATUS_ADDR;
        bus_if.bus_memread = 1'b1;
        #1;
        v   = bus_if.bus_rdata;
        hit = bus_if.bus_rd_hit;
        bus_if.bus_memread = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        logic [31:0] v;
        logic        h;
        int          n;
        n = 0;
        do begin
            read_status(v, h);
            n++;
        end while (!(v == 32'h1 && sbq.size() == 0 && tx_ready) && n < 400);
        $display("drain %s status=%h after %0d reads", tag, v, n);
        check(tag, v, 32'h0000_0001);
        check({tag, "_sb"}, 32'(sbq.size()), 32'h0);
    endtask

    initial begin
        logic        st;
        logic [31:0] v;
        logic        h;
        int          s0;

        bus_if.bus_addr     = '0;
        bus_if.bus_wdata    = '0;
        bus_if.bus_memwrite = 1'b0;
        bus_if.bus_memread  = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        bus_if.bus_addr = TX_ADDR;
        bus_if.bus_memwrite = 1'b1;
        #1;
        check("rst_stall", 32'(bus_if.bus_stall), 32'h0);
        bus_if.bus_memwrite = 1'b0;
        bus_if.bus_memread = 1'b1;
        #1;
        check("tx_addr_rd_hit", 32'(bus_if.bus_rd_hit), 32'h0);
        check("tx_addr_rdata", bus_if.bus_rdata, 32'h0);
        bus_if.bus_addr = STATUS_ADDR;
        #1;
        check("rst_rd_hit", 32'(bus_if.bus_rd_hit), 32'h1);
        check("rst_status", bus_if.bus_rdata, 32'h0000_0001);
        bus_if.bus_memread = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // single byte latency
        cpu_write(TX_ADDR, 32'h41, st);
        check("t1_stall", 32'(st), 32'h0);
        check("t1_start_e0", 32'(tx_start), 32'h0);
        @(posedge clk);
        #1;
        check("t1_start_e1", 32'(tx_start), 32'h1);
        check("t1_data", 32'(tx_data), 32'(exp_byte(8'h41)));
        @(posedge clk);
        #1;
        check("t1_start_drop", 32'(tx_start), 32'h0);
        wait_drain("t1_drain");

        // fill to full, ninth write stalls until the first pop
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            cpu_write(TX_ADDR, 32'(i), st);
            check($sformatf("t2_stall_%0d", i), 32'(st), 32'h0);
        end
        fork
            cpu_write(TX_ADDR, 32'h9, st);
            begin
                repeat (4) @(negedge clk);
                hold = 1'b0;
            end
        join
        check("t2_stall_9", 32'(st), 32'h1);
        wait_drain("t2_drain");

        // simultaneous push and pop with four queued
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) cpu_write(TX_ADDR, 32'h11 + 32'(i), st);
        read_status(v, h);
        check("t3_status_before", v, 32'h0000_0400);
        @(negedge clk);
        hold = 1'b0;
        cpu_write(TX_ADDR, 32'h15, st);
        check("t3_popped", 32'(tx_start), 32'h1);
        read_status(v, h);
        check("t3_status_after", v, 32'h0000_0404);
        wait_drain("t3_drain");

        // status with three queued and the FSM busy
        busy_len = 30;
        for (int i = 0; i < 4; i++) cpu_write(TX_ADDR, 32'h21 + 32'(i), st);
        read_status(v, h);
        check("t4_rd_hit", 32'(h), 32'h1);
        check("t4_status", v, 32'h0000_0304);
        wait_drain("t4_drain");

        // flush with five queued and one in flight
        for (int i = 0; i < 6; i++) cpu_write(TX_ADDR, 32'h31 + 32'(i), st);
        read_status(v, h);
        check("t5_status_before", v, 32'h0000_0504);
        check("t5_sb_queued", 32'(sbq.size()), 32'h5);
        cpu_write(STATUS_ADDR, 32'h1, st);
        sbq.delete();
        s0 = start_cnt;
        read_status(v, h);
        check("t5_status_flushed", v, 32'h0000_0005);
        wait_drain("t5_drain");
        repeat (10) @(negedge clk);
        check("t5_no_start", 32'(start_cnt), 32'(s0));
        busy_len = 3;

        // asynchronous reset while in START with the FIFO full
        ack_en = 1'b0;
        for (int i = 0; i < 9; i++) cpu_write(TX_ADDR, 32'h51 + 32'(i), st);
        @(negedge clk);
        bus_if.bus_addr     = TX_ADDR;
        bus_if.bus_wdata    = 32'h60;
        bus_if.bus_memwrite = 1'b1;
        #1;
        check("t6_stall_full", 32'(bus_if.bus_stall), 32'h1);
        check("t6_start_before", 32'(tx_start), 32'h1);
        rstn = 1'b0;
        #1;
        check("t6_start_rst", 32'(tx_start), 32'h0);
        check("t6_data_rst", 32'(tx_data), 32'h0);
        check("t6_stall_rst", 32'(bus_if.bus_stall), 32'h0);
        bus_if.bus_memwrite = 1'b0;
        bus_if.bus_addr     = STATUS_ADDR;
        bus_if.bus_memread  = 1'b1;
        #1;
        check("t6_status_rst", bus_if.bus_rdata, 32'h0000_0001);
        bus_if.bus_memread = 1'b0;
        sbq.delete();
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // recovery after reset
        cpu_write(TX_ADDR, 32'h07, st);
        wait_drain("t7_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
